mux_stream_arbiter: RTL and testbench
=====================================

Name: mux_stream_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 single-bit multiplexer channel in the decompressor datapath. Four serial bit-stream requesters compete for the one output channel. The block grants one requester at a time for a bounded burst, drives the mux select, and marks valid bits on the shared output. It sits between the per-stream decode stages and the downstream bit consumer.

Parameters:
BURST_LEN, 8, maximum bits transferred per grant; legal range 1..2^CNT_W.
CNT_W, 4, width of the internal burst counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, active-low, asynchronous.
req  input  4  per-requester request; bit i high means requester i has a bit on in_bit[i] this cycle.
in_bit  input  4  per-requester data bit.
sel  output  2  registered mux select; index of the current/last granted requester.
grant  output  4  registered one-hot grant; all-zero when idle.
out_bit  output  1  shared channel bit, in_bit[sel] through the 4:1 mux, gated to 0 when out_valid=0.
out_valid  output  1  high when out_bit carries a transferred bit.
burst_end  output  1  combinational; high in the final SERVE cycle of a grant.
busy  output  1  high while in SERVE.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, grant=0000, sel=00, ptr=00, count=0.
  - Therefore out_valid=0, out_bit=0, burst_end=0, busy=0.
- Internal registers:
  - ptr (2 bits): next-highest-priority index.
  - count (CNT_W bits): bits sent in the current burst.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise, search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and choose the first with req set.
  - Next edge: sel<=chosen, grant<=onehot(chosen), count<=0, state<=SERVE.
  - Latency is one cycle from request seen in IDLE to grant.
- SERVE:
  - Transfer condition: out_valid = req[sel]. When true, out_bit=in_bit[sel] and count increments.
  - Release condition:
    - req[sel]=0 (no transfer that cycle), or
    - a transfer with count==BURST_LEN-1.
  - burst_end=1 in the release cycle.
  - On the release edge: state<=IDLE, grant<=0000, ptr<=sel+1 (mod 4, so 3 wraps to 0); sel holds its value.
- Always one IDLE cycle between bursts (dead cycle). Re-arbitration happens only in IDLE, including when a single requester holds req continuously.
- Non-granted requesters' req and in_bit are ignored during SERVE. No preemption.
- A request that is asserted and then dropped while in IDLE before it is sampled is lost; there is no latching.
- Count never exceeds BURST_LEN-1 before release, so there is no counter wrap.
- With BURST_LEN=1, every grant lasts exactly one SERVE cycle.
- Reset asserted mid-burst: the burst is aborted immediately, all outputs return to reset values, and ptr returns to 0.
- Outputs during reset deassertion: the first arbitration happens on the first clk edge with rst_n=1 and state IDLE.

Test Plan:
1. Reset: pulse rst_n low mid-cycle with req=1111 -> grant=0000, sel=00, out_valid=0, busy=0 immediately and while rst_n=0.
2. Single requester: req=0001 held from cycle 0, in_bit[0] toggling -> grant=0001 cycles 1..8; out_valid=1 cycles 1..8 with out_bit matching in_bit[0]; burst_end at cycle 8; idle at cycle 9; regrant at cycle 10.
3. Round-robin fairness: req=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, each 8 valid bits, period 9 cycles; sel follows 0,1,2,3,0.
4. Early drop: requester 2 granted, req[2] low after 3 transferred bits -> burst_end in the cycle req[2]=0 with out_valid=0; next grant starts search at index 3; with req=0101, grant=0001.
5. Wrap priority: after serving requester 3, req=1001 -> grant=0001, not 1000.
6. Edge parameter: BURST_LEN=1, req=0011 held -> grant alternates 0001/0010, one valid bit each, every 2 cycles.

Source files
------------

// File: rtl/mux_stream_arbiter.sv
// Round-robin arbiter driving the shared 4:1 single-bit channel of the decompressor.
// One requester at a time is granted for a burst of up to BURST_LEN bits, then one idle cycle.
module mux_stream_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] in_bit,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       out_bit,
  output logic       out_valid,
  output logic       burst_end,
  output logic       busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             found;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign busy      = (state == SERVE);
  assign out_valid = busy && req[sel];
  assign out_bit   = out_valid && in_bit[sel];
  assign burst_end = busy && (!req[sel] || (count == LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            grant <= 4'b0001 << pick;
            count <= '0;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (out_valid)
            count <= count + CNT_W'(1);
          // sel is kept so the last-served index stays visible while idle.
          if (burst_end) begin
            state <= IDLE;
            grant <= 4'b0000;
            ptr   <= sel + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Directed self-checking bench for mux_stream_arbiter; a second instance runs with BURST_LEN=1.
module tb_mux_stream_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req, in_bit, req1, in_bit1;
  logic [1:0] sel, sel1;
  logic [3:0] grant, grant1;
  logic       out_bit, out_valid, burst_end, busy;
  logic       out_bit1, out_valid1, burst_end1, busy1;
  int         checks;
  int         errors;

  mux_stream_arbiter #(.BURST_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_bit(in_bit),
    .sel(sel), .grant(grant), .out_bit(out_bit), .out_valid(out_valid),
    .burst_end(burst_end), .busy(busy)
  );

  mux_stream_arbiter #(.BURST_LEN(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .in_bit(in_bit1),
    .sel(sel1), .grant(grant1), .out_bit(out_bit1), .out_valid(out_valid1),
    .burst_end(burst_end1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] b);
    req    = r;
    in_bit = b;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, {4'b0, grant}, 8'h00);
    checkOutput({tag, "_busy"}, {7'b0, busy}, 8'h00);
    checkOutput({tag, "_valid"}, {7'b0, out_valid}, 8'h00);
    checkOutput({tag, "_bit"}, {7'b0, out_bit}, 8'h00);
    checkOutput({tag, "_end"}, {7'b0, burst_end}, 8'h00);
  endtask

  task automatic checkXfer(input string tag, input logic [1:0] idx, input logic last);
    checkOutput({tag, "_grant"}, {4'b0, grant}, 8'(4'b0001 << idx));
    checkOutput({tag, "_sel"}, {6'b0, sel}, {6'b0, idx});
    checkOutput({tag, "_valid"}, {7'b0, out_valid}, 8'h01);
    checkOutput({tag, "_bit"}, {7'b0, out_bit}, {7'b0, in_bit[idx]});
    checkOutput({tag, "_end"}, {7'b0, burst_end}, {7'b0, last});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req1    = 4'b0000;
    in_bit1 = 4'b0000;
    applyStimulus(4'b0000, 4'b0000);

    // Reset state, then a mid-cycle reset pulse aborting a live grant.
    repeat (2) @(negedge clk);
    checkIdle("rst_init");
    checkOutput("rst_init_sel", {6'b0, sel}, 8'h00);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111);
    nextCycle();
    checkOutput("rst_pre_busy", {7'b0, busy}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    checkIdle("rst_async");
    checkOutput("rst_async_sel", {6'b0, sel}, 8'h00);
    nextCycle();
    checkIdle("rst_held");
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: burst of 8 with in_bit[0] toggling, dead cycle, regrant.
    applyStimulus(4'b0001, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      nextCycle();
      applyStimulus(4'b0001, {3'b000, c[0]});
      #1;
      checkXfer($sformatf("single_c%0d", c), 2'd0, c == 8);
    end
    nextCycle();
    checkIdle("single_dead");
    nextCycle();
    checkOutput("single_regrant", {4'b0, grant}, 8'h01);
    applyStimulus(4'b0000, 4'b0000);
    #1;
    checkOutput("single_drop_end", {7'b0, burst_end}, 8'h01);
    nextCycle();

    // Round-robin fairness from a fresh reset (ptr back to 0).
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      for (int c = 1; c <= 8; c++) begin
        nextCycle();
        applyStimulus(4'b1111, 4'($urandom));
        #1;
        checkXfer($sformatf("rr_g%0d_c%0d", k, c), 2'(k % 4), c == 8);
      end
      nextCycle();
      checkIdle($sformatf("rr_dead%0d", k));
      checkOutput($sformatf("rr_hold_sel%0d", k), {6'b0, sel}, 8'(k % 4));
    end

    // Early drop: requester 2 stops after 3 bits, next search starts at 3.
    applyStimulus(4'b0100, 4'b0100);
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      #1;
      checkXfer($sformatf("drop_c%0d", c), 2'd2, 1'b0);
    end
    nextCycle();
    applyStimulus(4'b0000, 4'b0100);
    #1;
    checkOutput("drop_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("drop_bit", {7'b0, out_bit}, 8'h00);
    checkOutput("drop_end", {7'b0, burst_end}, 8'h01);
    checkOutput("drop_busy", {7'b0, busy}, 8'h01);
    nextCycle();
    applyStimulus(4'b0101, 4'b0000);
    #1;
    checkIdle("drop_dead");
    nextCycle();
    checkOutput("drop_next_grant", {4'b0, grant}, 8'h01);
    applyStimulus(4'b0000, 4'b0000);
    nextCycle();

    // Wrap priority: after requester 3, pointer wraps to 0.
    applyStimulus(4'b1000, 4'b0000);
    nextCycle();
    checkOutput("wrap_grant3", {4'b0, grant}, 8'h08);
    applyStimulus(4'b0000, 4'b0000);
    nextCycle();
    applyStimulus(4'b1001, 4'b0000);
    nextCycle();
    checkOutput("wrap_grant", {4'b0, grant}, 8'h01);
    checkOutput("wrap_sel", {6'b0, sel}, 8'h00);
    applyStimulus(4'b0000, 4'b0000);
    nextCycle();

    // BURST_LEN=1 instance: grants alternate 0001/0010 every two cycles.
    req1    = 4'b0011;
    in_bit1 = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checkOutput($sformatf("b1_grant%0d", k), {4'b0, grant1}, (k % 2 == 0) ? 8'h01 : 8'h02);
      checkOutput($sformatf("b1_valid%0d", k), {7'b0, out_valid1}, 8'h01);
      checkOutput($sformatf("b1_end%0d", k), {7'b0, burst_end1}, 8'h01);
      checkOutput($sformatf("b1_bit%0d", k), {7'b0, out_bit1}, (k % 2 == 0) ? 8'h00 : 8'h01);
      nextCycle();
      checkOutput($sformatf("b1_idle%0d", k), {4'b0, grant1}, 8'h00);
      checkOutput($sformatf("b1_busy%0d", k), {7'b0, busy1}, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
